// File: rtl/controller_frame_rx.sv
// Purpose : assemble SYNC + payload + checksum frames from the SPI receive byte stream and latch the validated payload.
// Latency : result/error pulses and buttons_out/frame_count_out update one clk_in edge after the checksum byte (or after timer expiry).
// Backpres: none - every byte_valid_in pulse is consumed, one byte per cycle is sustained indefinitely.
//
// Ports:
//   clk_in, rst_in       single clock domain, asynchronous active-high reset
//   byte_in/byte_valid_in received byte and its 1-cycle qualifier
//   buttons_out          last validated payload, first payload byte in the MSBs
//   frame_valid_out      1-cycle pulse when buttons_out has just been updated
//   checksum_err_out     1-cycle pulse when a frame is dropped for a bad checksum
//   timeout_err_out      1-cycle pulse when a frame is dropped for an inter-byte stall
//   frame_count_out      validated frame count, wraps at 16'hFFFF
module controller_frame_rx #(
    parameter int          PAYLOAD_BYTES  = 2,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          TIMEOUT_CYCLES = 100_000
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic [7:0]                   byte_in,
    input  logic                         byte_valid_in,
    output logic [8*PAYLOAD_BYTES-1:0]   buttons_out,
    output logic                         frame_valid_out,
    output logic                         checksum_err_out,
    output logic                         timeout_err_out,
    output logic [15:0]                  frame_count_out
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1;

    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(PAYLOAD_BYTES - 1);
    localparam logic [IW-1:0] IDX_ONE    = IW'(1);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_PAYLOAD = 2'd1,
        ST_CHECK   = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Shadow payload: element PAYLOAD_BYTES-1 is the first byte received so
    // the packed vector maps straight onto buttons_out with byte 0 in the MSBs.
    logic [PAYLOAD_BYTES-1:0][7:0] shadow, shadow_nxt;
    logic [7:0]                    sum, sum_nxt;
    logic [IW-1:0]                 idx, idx_nxt;
    logic [TW-1:0]                 timer, timer_nxt;

    logic [8*PAYLOAD_BYTES-1:0]    buttons_nxt;
    logic [15:0]                   count_nxt;
    logic                          frame_valid_nxt;
    logic                          checksum_err_nxt;
    logic                          timeout_err_nxt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= ST_HUNT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        shadow_nxt       = shadow;
        sum_nxt          = sum;
        idx_nxt          = idx;
        timer_nxt        = timer;
        buttons_nxt      = buttons_out;
        count_nxt        = frame_count_out;
        frame_valid_nxt  = 1'b0;
        checksum_err_nxt = 1'b0;
        timeout_err_nxt  = 1'b0;

        case (state)
            ST_HUNT: begin
                // Only a SYNC byte opens a frame; the timer stays parked at zero.
                if (byte_valid_in && (byte_in == SYNC_BYTE)) begin
                    state_nxt = ST_PAYLOAD;
                    idx_nxt   = '0;
                    sum_nxt   = '0;
                    timer_nxt = '0;
                end
            end

            ST_PAYLOAD: begin
                // A byte equal to SYNC_BYTE here is ordinary payload data.
                if (byte_valid_in) begin
                    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                        if (idx == IW'(PAYLOAD_BYTES - 1 - i)) begin
                            shadow_nxt[i] = byte_in;
                        end
                    end
                    sum_nxt   = sum + byte_in;
                    timer_nxt = '0;
                    if (idx == IDX_LAST) begin
                        state_nxt = ST_CHECK;
                        idx_nxt   = '0;
                    end else begin
                        idx_nxt = idx + IDX_ONE;
                    end
                end else if (timer == TIMER_LAST) begin
                    state_nxt       = ST_HUNT;
                    timeout_err_nxt = 1'b1;
                    timer_nxt       = '0;
                    idx_nxt         = '0;
                    sum_nxt         = '0;
                end else begin
                    timer_nxt = timer + TIMER_ONE;
                end
            end

            ST_CHECK: begin
                if (byte_valid_in) begin
                    state_nxt = ST_HUNT;
                    timer_nxt = '0;
                    sum_nxt   = '0;
                    if (byte_in == sum) begin
                        buttons_nxt     = shadow;
                        count_nxt       = frame_count_out + 16'd1;
                        frame_valid_nxt = 1'b1;
                    end else begin
                        checksum_err_nxt = 1'b1;
                    end
                end else if (timer == TIMER_LAST) begin
                    state_nxt       = ST_HUNT;
                    timeout_err_nxt = 1'b1;
                    timer_nxt       = '0;
                    sum_nxt         = '0;
                end else begin
                    timer_nxt = timer + TIMER_ONE;
                end
            end

            default: begin
                state_nxt = ST_HUNT;
                idx_nxt   = '0;
                sum_nxt   = '0;
                timer_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            shadow           <= '0;
            sum              <= '0;
            idx              <= '0;
            timer            <= '0;
            buttons_out      <= '0;
            frame_count_out  <= '0;
            frame_valid_out  <= 1'b0;
            checksum_err_out <= 1'b0;
            timeout_err_out  <= 1'b0;
        end else begin
            shadow           <= shadow_nxt;
            sum              <= sum_nxt;
            idx              <= idx_nxt;
            timer            <= timer_nxt;
            buttons_out      <= buttons_nxt;
            frame_count_out  <= count_nxt;
            frame_valid_out  <= frame_valid_nxt;
            checksum_err_out <= checksum_err_nxt;
            timeout_err_out  <= timeout_err_nxt;
        end
    end

endmodule

// File: tb/tb_controller_frame_rx.sv
// Purpose : randomized and directed stimulus for controller_frame_rx, scored against a frame-level reference model.
// Latency : expected events are queued when the closing byte (or stall) is driven and popped when the DUT pulses.
// Backpres: none - the bench drives bytes freely, back-to-back or with arbitrary gaps.
module tb_controller_frame_rx;

    localparam int         PB   = 2;
    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TO   = 50;

    localparam int EV_FRAME = 0;
    localparam int EV_CKERR = 1;
    localparam int EV_TOERR = 2;

    logic            clk_in;
    logic            rst_in;
    logic [7:0]      byte_in;
    logic            byte_valid_in;
    logic [8*PB-1:0] buttons_out;
    logic            frame_valid_out;
    logic            checksum_err_out;
    logic            timeout_err_out;
    logic [15:0]     frame_count_out;

    controller_frame_rx #(
        .PAYLOAD_BYTES  (PB),
        .SYNC_BYTE      (SYNC),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .byte_in          (byte_in),
        .byte_valid_in    (byte_valid_in),
        .buttons_out      (buttons_out),
        .frame_valid_out  (frame_valid_out),
        .checksum_err_out (checksum_err_out),
        .timeout_err_out  (timeout_err_out),
        .frame_count_out  (frame_count_out)
    );

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    typedef struct {
        int          kind;
        logic [15:0] btn;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: a frame is a SYNC followed by the next PB+1 bytes,
    // provided no gap of TO consecutive idle cycles occurs inside it.
    bit          m_in_frame = 0;
    logic [7:0]  m_bytes[$];
    int          m_idle     = 0;
    logic [15:0] m_buttons  = '0;
    logic [15:0] m_count    = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_frame = 0;
        m_bytes.delete();
        m_idle    = 0;
        m_buttons = '0;
        m_count   = '0;
        exp_q.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] b);
        exp_t e;
        int   s;
        if (!m_in_frame) begin
            if (v && b == SYNC) begin
                m_in_frame = 1;
                m_bytes.delete();
                m_idle = 0;
            end
        end else if (v) begin
            m_idle = 0;
            m_bytes.push_back(b);
            if (m_bytes.size() == PB + 1) begin
                s = 0;
                for (int i = 0; i < PB; i++) s += int'(m_bytes[i]);
                if (m_bytes[PB] == 8'(s % 256)) begin
                    m_buttons = '0;
                    for (int i = 0; i < PB; i++) m_buttons = (m_buttons << 8) | 16'(m_bytes[i]);
                    m_count = m_count + 16'd1;
                    e.kind  = EV_FRAME;
                end else begin
                    e.kind = EV_CKERR;
                end
                e.btn = m_buttons;
                e.cnt = m_count;
                exp_q.push_back(e);
                m_in_frame = 0;
            end
        end else begin
            m_idle++;
            if (m_idle == TO) begin
                e.kind = EV_TOERR;
                e.btn  = m_buttons;
                e.cnt  = m_count;
                exp_q.push_back(e);
                m_in_frame = 0;
            end
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] b);
        @(negedge clk_in);
        byte_valid_in = v;
        byte_in       = v ? b : 8'($urandom);
        model_step(v, byte_in);
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) drive(1'b0, 8'h00);
        drive(1'b1, b);
    endtask

    task automatic send4(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c,
                         input logic [7:0] d, input int gap);
        send(a, gap);
        send(b, gap);
        send(c, gap);
        send(d, gap);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'h00);
    endtask

    function automatic int rgap();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 12) return 0;
        if (r < 17) return int'($urandom_range(1, 4));
        return int'($urandom_range(TO - 3, TO + 3));
    endfunction

    // Monitor: every cycle, outputs must track the model; each pulse consumes one expectation.
    initial begin
        exp_t e;
        int   npulse;
        int   kind;
        forever begin
            @(posedge clk_in);
            #1;
            if (rst_in !== 1'b0) continue;
            npulse = int'(frame_valid_out) + int'(checksum_err_out) + int'(timeout_err_out);
            check("pulse_exclusive", (npulse > 1) ? 32'd1 : 32'd0, 32'd0);
            if (npulse >= 1) begin
                kind = frame_valid_out ? EV_FRAME : (checksum_err_out ? EV_CKERR : EV_TOERR);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got kind %0d, expected no event (t=%0t)", kind, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", 32'(kind), 32'(e.kind));
                    check("event_buttons", 32'(buttons_out), 32'(e.btn));
                    check("event_count", 32'(frame_count_out), 32'(e.cnt));
                end
            end
            check("buttons_track", 32'(buttons_out), 32'(m_buttons));
            check("count_track", 32'(frame_count_out), 32'(m_count));
        end
    end

    initial begin
        logic [7:0] p0, p1, ck;
        int         sel;

        rst_in        = 1'b1;
        byte_in       = 8'h00;
        byte_valid_in = 1'b0;
        model_reset();
        #1;
        check("reset_buttons", 32'(buttons_out), 32'h0);
        check("reset_count", 32'(frame_count_out), 32'h0);
        check("reset_fv", 32'(frame_valid_out), 32'h0);
        check("reset_ck", 32'(checksum_err_out), 32'h0);
        check("reset_to", 32'(timeout_err_out), 32'h0);
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        idle(2);

        // Spaced frame.
        send4(8'hA5, 8'h12, 8'h34, 8'h46, 10);
        idle(3);
        check("spaced_buttons", 32'(buttons_out), 32'h1234);
        check("spaced_count", 32'(frame_count_out), 32'd1);

        // Leading junk then a back-to-back frame.
        send(8'h00, 0); send(8'hFF, 0); send(8'h3C, 0);
        send4(8'hA5, 8'hAB, 8'hCD, 8'h78, 0);
        idle(2);
        check("b2b_buttons", 32'(buttons_out), 32'hABCD);
        check("b2b_count", 32'(frame_count_out), 32'd2);

        // Bad checksum.
        send4(8'hA5, 8'h12, 8'h34, 8'h00, 0);
        idle(2);
        check("ckerr_buttons", 32'(buttons_out), 32'hABCD);
        check("ckerr_count", 32'(frame_count_out), 32'd2);

        // Stall mid-frame, then recovery.
        send(8'hA5, 0); send(8'h12, 0);
        idle(60);
        send4(8'hA5, 8'h56, 8'h78, 8'hCE, 0);
        idle(2);
        check("recover_buttons", 32'(buttons_out), 32'h5678);
        check("recover_count", 32'(frame_count_out), 32'd3);

        // Checksum wrap and SYNC value used as data.
        send4(8'hA5, 8'hFF, 8'h02, 8'h01, 0);
        idle(2);
        check("wrap_buttons", 32'(buttons_out), 32'hFF02);
        send4(8'hA5, 8'hA5, 8'h00, 8'hA5, 0);
        idle(2);
        check("syncdata_buttons", 32'(buttons_out), 32'hA500);
        check("syncdata_count", 32'(frame_count_out), 32'd5);

        // Largest surviving gap, then the first gap that expires.
        send4(8'hA5, 8'h01, 8'h02, 8'h03, TO - 1);
        idle(2);
        check("gap_max_buttons", 32'(buttons_out), 32'h0102);
        send(8'hA5, 0);
        send(8'h77, TO);
        send(8'h88, 0); send(8'hFF, 0);
        idle(2);
        check("gap_expire_buttons", 32'(buttons_out), 32'h0102);
        check("gap_expire_count", 32'(frame_count_out), 32'd6);

        // Asynchronous reset mid-frame.
        send(8'hA5, 0); send(8'h12, 0);
        @(negedge clk_in);
        byte_valid_in = 1'b0;
        rst_in        = 1'b1;
        model_reset();
        #1;
        check("midrst_buttons", 32'(buttons_out), 32'h0);
        check("midrst_count", 32'(frame_count_out), 32'h0);
        @(negedge clk_in);
        rst_in = 1'b0;
        send4(8'hA5, 8'h11, 8'h22, 8'h33, 0);
        idle(2);
        check("postrst_buttons", 32'(buttons_out), 32'h1122);
        check("postrst_count", 32'(frame_count_out), 32'd1);

        // Randomized traffic: good/bad checksums, junk, truncation and near-limit gaps.
        for (int f = 0; f < 250; f++) begin
            sel = int'($urandom_range(0, 9));
            if (sel == 0) begin
                repeat (int'($urandom_range(1, 3))) send(8'($urandom), rgap());
            end else begin
                p0 = 8'($urandom);
                p1 = 8'($urandom);
                ck = (sel <= 6) ? 8'(p0 + p1) : 8'($urandom);
                send(SYNC, rgap());
                send(p0, rgap());
                send(p1, rgap());
                if (sel != 9) send(ck, rgap());
            end
        end
        idle(TO + 5);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL pending_events: got %0d outstanding, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
